// File: rtl/pcs_decoder_rx.sv
// pcs_decoder_rx -- 64b/66b receive decoder for the 100GbE PCS.
//
// Takes one 66-bit coded block per enabled cycle, classifies it as
// D / S / C / T / E, runs the RX state machine and emits one CGMII word
// (64-bit data, byte 0 in [63:56], plus an 8-bit control mask, bit 7 =
// byte 0) two clocks after the block strobe.
//
// Ports:
//   i_clock      clock
//   i_reset      synchronous, active-high reset
//   i_enable     block strobe; i_rx_coded is valid this cycle
//   i_rx_coded   coded block: [65:64] sync header, [63:56] block type
//   o_rx_data    decoded CGMII data
//   o_rx_ctrl    CGMII control mask, 1 = control character
//   o_valid      one-cycle pulse when o_rx_data/o_rx_ctrl are updated
//   o_r_type     class of emitted block {D,S,C,T}; 4'b0000 = E
//   o_state      current RX state (debug)
//   o_err_count  saturating count of emitted error blocks
//                (only when PCS_DECODER_ERR_CNT_EN is defined)

module pcs_decoder_rx #(
  parameter int LEN_CODED_BLOCK = 66,
  parameter int LEN_RX_DATA     = 64,
  parameter int LEN_RX_CTRL     = 8
) (
  input  logic                       i_clock,
  input  logic                       i_reset,
  input  logic                       i_enable,
  input  logic [LEN_CODED_BLOCK-1:0] i_rx_coded,
  output logic [LEN_RX_DATA-1:0]     o_rx_data,
  output logic [LEN_RX_CTRL-1:0]     o_rx_ctrl,
  output logic                       o_valid,
  output logic [3:0]                 o_r_type,
  output logic [2:0]                 o_state
`ifdef PCS_DECODER_ERR_CNT_EN
  ,
  output logic [15:0]                o_err_count
`endif
);

  typedef enum logic [2:0] {
    RX_INIT = 3'd0,
    RX_C    = 3'd1,
    RX_D    = 3'd2,
    RX_T    = 3'd3,
    RX_E    = 3'd4
  } rx_state_t;

  localparam logic [3:0] CLS_D = 4'b1000;
  localparam logic [3:0] CLS_S = 4'b0100;
  localparam logic [3:0] CLS_C = 4'b0010;
  localparam logic [3:0] CLS_T = 4'b0001;
  localparam logic [3:0] CLS_E = 4'b0000;

  localparam logic [63:0] IDLE_WORD  = {8{8'h07}};
  localparam logic [63:0] ERROR_WORD = {8{8'hFE}};

  // Stage 1
  logic [LEN_CODED_BLOCK-1:0] blk_q;
  logic                       stage_valid;

  // Stage 2
  rx_state_t   state;
  rx_state_t   nxt_state;
  logic [63:0] dec_data;
  logic [7:0]  dec_ctrl;
  logic [3:0]  dec_class;

  logic [1:0]  sync_hdr;
  logic [7:0]  blk_type;
  logic [55:0] payload;
  logic [63:0] term_data;
  logic [6:0]  ch;
  logic [2:0]  term_k;
  logic        is_term;
  logic        bad;
  logic [7:0]  os_code;

`ifdef PCS_DECODER_ERR_CNT_EN
  logic [15:0] err_cnt;
  assign o_err_count = err_cnt;
`endif

  function automatic logic char_ok(input logic [6:0] c);
    return (c == 7'h00) || (c == 7'h1E);
  endfunction

  function automatic logic [7:0] char_to_byte(input logic [6:0] c);
    return (c == 7'h1E) ? 8'hFE : 8'h07;
  endfunction

  // Block classification and payload expansion
  always_comb begin
    sync_hdr  = blk_q[65:64];
    blk_type  = blk_q[63:56];
    payload   = blk_q[55:0];
    // Left-aligned payload so terminate data byte i sits at [63-8i -: 8]
    term_data = {payload, 8'h00};
    ch        = '0;
    bad       = 1'b0;
    os_code   = 8'h00;
    dec_data  = '0;
    dec_ctrl  = '1;
    dec_class = CLS_E;
    is_term   = 1'b1;
    term_k    = 3'd0;

    case (blk_type)
      8'h87:   term_k = 3'd0;
      8'h99:   term_k = 3'd1;
      8'hAA:   term_k = 3'd2;
      8'hB4:   term_k = 3'd3;
      8'hCC:   term_k = 3'd4;
      8'hD2:   term_k = 3'd5;
      8'hE1:   term_k = 3'd6;
      8'hFF:   term_k = 3'd7;
      default: is_term = 1'b0;
    endcase

    if (sync_hdr == 2'b01) begin
      dec_data  = blk_q[63:0];
      dec_ctrl  = 8'h00;
      dec_class = CLS_D;
    end else if (sync_hdr == 2'b10) begin
      if (blk_type == 8'h1E) begin
        dec_class = CLS_C;
        dec_ctrl  = 8'hFF;
        for (int unsigned i = 0; i < 8; i++) begin
          ch = payload[7*(7-i) +: 7];
          dec_data[63-8*i -: 8] = char_to_byte(ch);
          if (!char_ok(ch)) bad = 1'b1;
        end
      end else if (blk_type == 8'h78) begin
        dec_class = CLS_S;
        dec_ctrl  = 8'h80;
        dec_data  = {8'hFB, payload};
      end else if (blk_type == 8'h4B) begin
        dec_class = CLS_C;
        dec_ctrl  = 8'h8F;
        if (blk_q[31:28] == 4'h0)      os_code = 8'h9C;
        else if (blk_q[31:28] == 4'hF) os_code = 8'h5C;
        else                           bad = 1'b1;
        if (blk_q[27:0] != '0) bad = 1'b1;
        dec_data = {os_code, blk_q[55:32], IDLE_WORD[31:0]};
      end else if (is_term) begin
        dec_class = CLS_T;
        dec_ctrl  = 8'hFF >> term_k;
        // Chars always occupy the low end of the payload; pad bits
        // between the data bytes and the chars are never inspected.
        for (int unsigned i = 0; i < 8; i++) begin
          if (i < 32'(term_k)) begin
            dec_data[63-8*i -: 8] = term_data[63-8*i -: 8];
          end else if (i == 32'(term_k)) begin
            dec_data[63-8*i -: 8] = 8'hFD;
          end else begin
            ch = payload[7*(7-i) +: 7];
            dec_data[63-8*i -: 8] = char_to_byte(ch);
            if (!char_ok(ch)) bad = 1'b1;
          end
        end
      end else begin
        bad = 1'b1;
      end
    end else begin
      bad = 1'b1;
    end

    if (bad) dec_class = CLS_E;
  end

  // RX state transitions
  always_comb begin
    nxt_state = RX_E;
    case (state)
      RX_INIT, RX_C, RX_T: begin
        if (dec_class == CLS_C)      nxt_state = RX_C;
        else if (dec_class == CLS_S) nxt_state = RX_D;
        else                         nxt_state = RX_E;
      end
      RX_D: begin
        if (dec_class == CLS_D)      nxt_state = RX_D;
        else if (dec_class == CLS_T) nxt_state = RX_T;
        else                         nxt_state = RX_E;
      end
      RX_E: begin
        if (dec_class == CLS_C)                              nxt_state = RX_C;
        else if (dec_class == CLS_S || dec_class == CLS_D)   nxt_state = RX_D;
        else if (dec_class == CLS_T)                         nxt_state = RX_T;
        else                                                 nxt_state = RX_E;
      end
      default: nxt_state = RX_E;
    endcase
  end

  always_ff @(posedge i_clock) begin
    if (i_reset) begin
      blk_q       <= '0;
      stage_valid <= 1'b0;
      state       <= RX_INIT;
      o_rx_data   <= IDLE_WORD;
      o_rx_ctrl   <= '1;
      o_valid     <= 1'b0;
      o_r_type    <= CLS_E;
`ifdef PCS_DECODER_ERR_CNT_EN
      err_cnt     <= '0;
`endif
    end else begin
      stage_valid <= i_enable;
      if (i_enable) blk_q <= i_rx_coded;

      o_valid <= stage_valid;
      if (stage_valid) begin
        state <= nxt_state;
        if (nxt_state == RX_E) begin
          o_rx_data <= ERROR_WORD;
          o_rx_ctrl <= '1;
          o_r_type  <= CLS_E;
`ifdef PCS_DECODER_ERR_CNT_EN
          if (err_cnt != '1) err_cnt <= err_cnt + 16'd1;
`endif
        end else begin
          o_rx_data <= dec_data;
          o_rx_ctrl <= dec_ctrl;
          o_r_type  <= dec_class;
        end
      end
    end
  end

  assign o_state = state;

endmodule

// File: tb/tb_pcs_decoder_rx.sv
// tb_pcs_decoder_rx -- self-checking bench for pcs_decoder_rx.
// Directed frames with literal expectations, then randomized blocks
// checked every cycle against a behavioural model of the decoder.
// Define PCS_DECODER_ERR_CNT_EN to also exercise o_err_count.

module tb_pcs_decoder_rx;

  logic        i_clock = 1'b0;
  logic        i_reset;
  logic        i_enable;
  logic [65:0] i_rx_coded;
  logic [63:0] o_rx_data;
  logic [7:0]  o_rx_ctrl;
  logic        o_valid;
  logic [3:0]  o_r_type;
  logic [2:0]  o_state;
`ifdef PCS_DECODER_ERR_CNT_EN
  logic [15:0] o_err_count;
`endif

  pcs_decoder_rx #(
    .LEN_CODED_BLOCK(66),
    .LEN_RX_DATA(64),
    .LEN_RX_CTRL(8)
  ) dut (
    .i_clock(i_clock),
    .i_reset(i_reset),
    .i_enable(i_enable),
    .i_rx_coded(i_rx_coded),
    .o_rx_data(o_rx_data),
    .o_rx_ctrl(o_rx_ctrl),
    .o_valid(o_valid),
    .o_r_type(o_r_type),
    .o_state(o_state)
`ifdef PCS_DECODER_ERR_CNT_EN
    ,
    .o_err_count(o_err_count)
`endif
  );

  always #5 i_clock = ~i_clock;

  // Debug state numbering of the design
  localparam int ST_INIT = 0, ST_C = 1, ST_D = 2, ST_T = 3, ST_E = 4;
  // Block classes used by the model
  localparam int K_E = 0, K_D = 1, K_S = 2, K_C = 3, K_T = 4;

  localparam logic [63:0] IDLE64 = 64'h0707070707070707;
  localparam logic [63:0] ERR64  = 64'hFEFEFEFEFEFEFEFE;
  localparam logic [65:0] CIDLE  = {2'b10, 8'h1E, 56'h0};

  logic [7:0] tcodes [8] = '{8'h87, 8'h99, 8'hAA, 8'hB4, 8'hCC, 8'hD2, 8'hE1, 8'hFF};

  int n_cmp = 0;
  int n_err = 0;
  bit cmp_en = 1'b0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  function automatic int ch_val(input int c);
    if (c == 0)     return 8'h07;
    if (c == 'h1E)  return 8'hFE;
    return -1;
  endfunction

  task automatic model_decode(input logic [65:0] b, output logic [63:0] d,
                              output logic [7:0] c, output int cls);
    logic [55:0] p;
    int by [8];
    int k;
    bit bad;
    p = b[55:0];
    d = '0;
    c = 8'hFF;
    cls = K_E;
    bad = 1'b0;
    if (b[65:64] == 2'b01) begin
      d = b[63:0]; c = 8'h00; cls = K_D; return;
    end
    if (b[65:64] != 2'b10) return;
    k = -1;
    for (int t = 0; t < 8; t++) if (b[63:56] == tcodes[t]) k = t;
    if (b[63:56] == 8'h1E) begin
      cls = K_C;
      for (int j = 0; j < 8; j++) begin
        by[j] = ch_val(int'((p >> (7*(7-j))) & 56'h7F));
        if (by[j] < 0) bad = 1'b1;
      end
    end else if (b[63:56] == 8'h78) begin
      cls = K_S; c = 8'h80;
      by[0] = 'hFB;
      for (int j = 1; j < 8; j++) by[j] = int'((p >> (56-8*j)) & 56'hFF);
    end else if (b[63:56] == 8'h4B) begin
      int oc;
      cls = K_C; c = 8'h8F;
      oc = int'((p >> 28) & 56'hF);
      if (oc == 0)        by[0] = 'h9C;
      else if (oc == 15)  by[0] = 'h5C;
      else begin by[0] = 0; bad = 1'b1; end
      if ((p & 56'hFFFFFFF) != 0) bad = 1'b1;
      for (int j = 1; j < 4; j++) by[j] = int'((p >> (56-8*j)) & 56'hFF);
      for (int j = 4; j < 8; j++) by[j] = 'h07;
    end else if (k >= 0) begin
      cls = K_T;
      c = 8'(8'hFF >> k);
      for (int j = 0; j < 8; j++) begin
        if (j < k)       by[j] = int'((p >> (48-8*j)) & 56'hFF);
        else if (j == k) by[j] = 'hFD;
        else begin
          by[j] = ch_val(int'((p >> (7*(7-j))) & 56'h7F));
          if (by[j] < 0) bad = 1'b1;
        end
      end
    end else begin
      bad = 1'b1;
    end
    if (bad) cls = K_E;
    else for (int j = 0; j < 8; j++) d = (d << 8) | 64'(by[j] & 'hFF);
  endtask

  function automatic int model_next(input int s, input int cls);
    case (s)
      ST_D:    return (cls == K_D) ? ST_D : (cls == K_T) ? ST_T : ST_E;
      ST_E:    return (cls == K_C) ? ST_C : (cls == K_S || cls == K_D) ? ST_D :
                      (cls == K_T) ? ST_T : ST_E;
      default: return (cls == K_C) ? ST_C : (cls == K_S) ? ST_D : ST_E;
    endcase
  endfunction

  function automatic logic [3:0] rtype_of(input int cls);
    case (cls)
      K_D:     return 4'b1000;
      K_S:     return 4'b0100;
      K_C:     return 4'b0010;
      K_T:     return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  bit          m_pv;
  logic [65:0] m_blk;
  bit          m_valid;
  int          m_state;
  logic [63:0] m_data;
  logic [7:0]  m_ctrl;
  logic [3:0]  m_rtype;
  logic [15:0] m_err;

  always @(posedge i_clock) begin
    logic [63:0] d;
    logic [7:0]  c;
    int cls, ns;
    if (i_reset) begin
      m_pv <= 0; m_blk <= '0; m_valid <= 0; m_state <= ST_INIT;
      m_data <= IDLE64; m_ctrl <= 8'hFF; m_rtype <= 4'b0000; m_err <= '0;
    end else begin
      m_valid <= m_pv;
      if (m_pv) begin
        model_decode(m_blk, d, c, cls);
        ns = model_next(m_state, cls);
        m_state <= ns;
        if (ns == ST_E) begin
          m_data <= ERR64; m_ctrl <= 8'hFF; m_rtype <= 4'b0000;
          m_err <= (m_err == 16'hFFFF) ? m_err : m_err + 16'd1;
        end else begin
          m_data <= d; m_ctrl <= c; m_rtype <= rtype_of(cls);
        end
      end
      m_pv <= i_enable;
      if (i_enable) m_blk <= i_rx_coded;
    end
  end

  always @(negedge i_clock) begin
    if (cmp_en) begin
      chk("valid", 64'(o_valid), 64'(m_valid));
      chk("data",  o_rx_data, m_data);
      chk("ctrl",  64'(o_rx_ctrl), 64'(m_ctrl));
      chk("rtype", 64'(o_r_type), 64'(m_rtype));
      chk("state", 64'(o_state), 64'(m_state));
`ifdef PCS_DECODER_ERR_CNT_EN
      chk("errcnt", 64'(o_err_count), 64'(m_err));
`endif
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic send(input logic [65:0] b);
    i_enable = 1'b1;
    i_rx_coded = b;
    @(posedge i_clock); @(negedge i_clock);
    i_enable = 1'b0;
  endtask

  // Send one block and return once its output is visible
  task automatic sendw(input logic [65:0] b);
    send(b);
    @(posedge i_clock); @(negedge i_clock);
  endtask

  task automatic out_chk(input string nm, input logic [63:0] d, input logic [7:0] c,
                         input logic [3:0] rt, input int st);
    chk({nm, "_valid"}, 64'(o_valid), 64'd1);
    chk({nm, "_data"},  o_rx_data, d);
    chk({nm, "_ctrl"},  64'(o_rx_ctrl), 64'(c));
    chk({nm, "_rtype"}, 64'(o_r_type), 64'(rt));
    chk({nm, "_state"}, 64'(o_state), 64'(st));
  endtask

  function automatic logic [65:0] gen_block();
    logic [63:0] r;
    logic [55:0] p;
    int sel, k, cs;
    r = {$urandom(), $urandom()};
    p = r[55:0];
    sel = int'($urandom_range(0, 9));
    case (sel)
      0, 1, 9: return {2'b01, r};
      2: return {2'b10, 8'h78, p};
      3: begin
        for (int j = 0; j < 8; j++) begin
          cs = int'($urandom_range(0, 15));
          p[7*(7-j) +: 7] = (cs < 13) ? 7'h00 : (cs < 15) ? 7'h1E : 7'($urandom());
        end
        return {2'b10, 8'h1E, p};
      end
      4: begin
        cs = int'($urandom_range(0, 5));
        p[31:28] = (cs < 2) ? 4'h0 : (cs < 4) ? 4'hF : 4'($urandom());
        if ($urandom_range(0, 4) != 0) p[27:0] = '0;
        return {2'b10, 8'h4B, p};
      end
      5, 6: begin
        k = int'($urandom_range(0, 7));
        for (int j = k + 1; j < 8; j++) begin
          cs = int'($urandom_range(0, 15));
          p[7*(7-j) +: 7] = (cs < 13) ? 7'h00 : (cs < 15) ? 7'h1E : 7'($urandom());
        end
        return {2'b10, tcodes[k], p};
      end
      7: return {($urandom_range(0, 1) == 0) ? 2'b00 : 2'b11, r};
      default: return {2'b10, r};
    endcase
  endfunction

  // ---------------- main sequence ----------------
  initial begin
    i_reset = 1'b1;
    i_enable = 1'b0;
    i_rx_coded = '0;
    @(posedge i_clock); @(negedge i_clock);
    cmp_en = 1'b1;
    @(posedge i_clock); @(negedge i_clock);
    chk("rst_valid", 64'(o_valid), 64'd0);
    chk("rst_data",  o_rx_data, IDLE64);
    chk("rst_ctrl",  64'(o_rx_ctrl), 64'hFF);
    chk("rst_rtype", 64'(o_r_type), 64'd0);
    chk("rst_state", 64'(o_state), 64'(ST_INIT));
    i_reset = 1'b0;

    // Four back-to-back idle control blocks
    for (int i = 0; i < 6; i++) begin
      i_enable = (i < 4);
      i_rx_coded = CIDLE;
      @(posedge i_clock); @(negedge i_clock);
      if (i == 0 || i == 5) chk("idle_gap_valid", 64'(o_valid), 64'd0);
      else out_chk("idle", IDLE64, 8'hFF, 4'b0010, ST_C);
    end
    i_enable = 1'b0;

    // Frame S, D, T3
    sendw({2'b10, 8'h78, 56'h11223344556677});
    out_chk("sfd", 64'hFB11223344556677, 8'h80, 4'b0100, ST_D);
    sendw({2'b01, 64'hA5A5A5A5A5A5A5A5});
    out_chk("dat", 64'hA5A5A5A5A5A5A5A5, 8'h00, 4'b1000, ST_D);
    sendw({2'b10, 8'hB4, 24'hAABBCC, 4'h0, 28'h0});
    out_chk("t3", 64'hAABBCCFD07070707, 8'h1F, 4'b0001, ST_T);

    // Data without start from RX_C, then recovery
    sendw(CIDLE);
    out_chk("c_again", IDLE64, 8'hFF, 4'b0010, ST_C);
    sendw({2'b01, 64'h0123456789ABCDEF});
    out_chk("d_no_s", ERR64, 8'hFF, 4'b0000, ST_E);
    sendw(CIDLE);
    out_chk("recover", IDLE64, 8'hFF, 4'b0010, ST_C);

    // Bad sync header inside a frame, then ordered set
    sendw({2'b10, 8'h78, 56'h0});
    sendw({2'b11, 64'h0123456789ABCDEF});
    out_chk("bad_sh", ERR64, 8'hFF, 4'b0000, ST_E);
    sendw({2'b10, 8'h4B, 24'h000001, 4'h0, 28'h0});
    out_chk("oset", 64'h9C00000107070707, 8'h8F, 4'b0010, ST_C);

    // Reset while a start block is in flight
    send({2'b10, 8'h78, 56'h11223344556677});
    i_reset = 1'b1;
    @(posedge i_clock); @(negedge i_clock);
    i_reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      chk("rstmid_valid", 64'(o_valid), 64'd0);
      chk("rstmid_data",  o_rx_data, IDLE64);
      chk("rstmid_ctrl",  64'(o_rx_ctrl), 64'hFF);
      chk("rstmid_state", 64'(o_state), 64'(ST_INIT));
      @(posedge i_clock); @(negedge i_clock);
    end

`ifdef PCS_DECODER_ERR_CNT_EN
    for (int i = 0; i < 3; i++) sendw({2'b10, 8'h55, 56'h0});
    chk("errcnt_3", 64'(o_err_count), 64'd3);
    i_enable = 1'b1;
    i_rx_coded = {2'b10, 8'h55, 56'h0};
    for (int i = 0; i < 65540; i++) begin
      @(posedge i_clock); @(negedge i_clock);
    end
    i_enable = 1'b0;
    repeat (3) begin @(posedge i_clock); @(negedge i_clock); end
    chk("errcnt_sat", 64'(o_err_count), 64'hFFFF);
    i_reset = 1'b1;
    @(posedge i_clock); @(negedge i_clock);
    i_reset = 1'b0;
    chk("errcnt_clr", 64'(o_err_count), 64'd0);
`endif

    // Randomized traffic against the model
    for (int i = 0; i < 4000; i++) begin
      i_reset = ($urandom_range(0, 299) == 0);
      i_enable = ($urandom_range(0, 9) < 8);
      i_rx_coded = gen_block();
      @(posedge i_clock); @(negedge i_clock);
    end
    i_reset = 1'b0;
    i_enable = 1'b0;
    repeat (4) begin @(posedge i_clock); @(negedge i_clock); end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
